// File: rtl/seq_game_pkg.sv
// Shared types for the sequence-memory game datapath:
// sequence ROM contents, LED mux encodings and scoring FSM states.
package seq_game_pkg;

    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_EXP   = 2'b01;
    localparam logic [1:0] LED_BTN   = 2'b10;
    localparam logic [1:0] LED_BLINK = 2'b11;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_RD,
        SC_ACC,
        SC_DONE
    } score_state_e;

    // One-hot sequence word; each bank is the base walk rotated by 3 buttons.
    function automatic logic [31:0] rom_word(
        input int bank,
        input int addr,
        input int n_btn
    );
        return 32'd1 << ((addr + 3 * bank) % n_btn);
    endfunction

endpackage

// File: rtl/seq_game_datapath_p_if.sv
// Scoring handshake between the game controller and the datapath:
// start/clear strobes in, running score with busy/done status out.
interface seq_game_datapath_p_if #(
    parameter int SCORE_W = 8
);
    logic               score_clr;
    logic               score_start;
    logic [SCORE_W-1:0] score;
    logic               score_busy;
    logic               score_done;

    modport master (
        output score_clr, score_start,
        input  score, score_busy, score_done
    );

    modport slave (
        input  score_clr, score_start,
        output score, score_busy, score_done
    );
endinterface

// File: rtl/seq_game_score_unit.sv
// Self-sequenced scorer: walks the per-round error RAM up to the current
// limit and deducts a weighted penalty from the score, saturating at zero.
module seq_game_score_unit
    import seq_game_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int ERR_W      = 4,
    parameter  int SCORE_W    = 8,
    parameter  int SCORE_INIT = 100,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    seq_game_datapath_p_if.slave sif,
    input  logic [ADDR_W-1:0]   limit,
    output logic [ADDR_W-1:0]   rd_idx,
    input  logic [ERR_W-1:0]    rd_data
);

    score_state_e       state;
    score_state_e       state_n;
    logic [ADDR_W-1:0]  idx;
    logic [SCORE_W-1:0] score_q;
    logic [31:0]        ded;
    logic [31:0]        score_ext;
    logic [31:0]        score_sub;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)               state <= SC_IDLE;
        else if (sif.score_clr)  state <= SC_IDLE;
        else                     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            SC_IDLE: if (sif.score_start) state_n = SC_RD;
            SC_RD:   state_n = SC_ACC;
            SC_ACC:  state_n = (idx == limit) ? SC_DONE : SC_RD;
            SC_DONE: state_n = SC_IDLE;
        endcase
    end

    always_comb begin
        sif.score_busy = (state == SC_RD) || (state == SC_ACC);
        sif.score_done = (state == SC_DONE);
        rd_idx         = idx;
    end

    // Earlier rounds weigh more; only every second error costs points.
    assign ded       = (32'(DEPTH - 1) - 32'(idx)) * 32'(rd_data >> 1);
    assign score_ext = 32'(score_q);
    assign score_sub = (score_ext > ded) ? score_ext - ded : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            score_q <= SCORE_W'(SCORE_INIT);
        end else if (sif.score_clr) begin
            score_q <= SCORE_W'(SCORE_INIT);
        end else if (state == SC_IDLE && sif.score_start) begin
            idx <= '0;
        end else if (state == SC_ACC) begin
            score_q <= SCORE_W'(score_sub);
            idx     <= idx + 1'b1;
        end
    end

    assign sif.score = score_q;

endmodule

// File: rtl/seq_game_datapath_p.sv
// Datapath for the sequence-memory game: counters, sequence ROM, press
// detection, timers, LED mux, error RAM and the scoring unit.
module seq_game_datapath_p
    import seq_game_pkg::*;
#(
    parameter  int N_BTN       = 7,
    parameter  int DEPTH       = 16,
    parameter  int N_BANKS     = 2,
    parameter  int ERR_W       = 4,
    parameter  int SCORE_W     = 8,
    parameter  int SCORE_INIT  = 100,
    parameter  int TIMEOUT_CYC = 5000,
    parameter  int BLINK_CYC   = 500,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int BANK_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     btn,
    input  logic [BANK_W-1:0]    bank_sel,
    input  logic [ADDR_W-1:0]    level_len,
    input  logic                 clr_limit,
    input  logic                 inc_limit,
    input  logic                 clr_addr,
    input  logic                 inc_addr,
    input  logic                 load_play,
    input  logic                 clr_timeout,
    input  logic                 cnt_timeout,
    input  logic                 clr_blink,
    input  logic                 cnt_blink,
    input  logic [1:0]           led_mode,
    input  logic                 err_clr,
    input  logic                 err_inc,
    input  logic                 err_write,
    input  logic                 err_clr_mem,
    seq_game_datapath_p_if.slave sif,
    output logic                 limit_at_level,
    output logic                 addr_eq_limit,
    output logic                 addr_last,
    output logic                 play_match,
    output logic                 play_pulse,
    output logic                 multi_press,
    output logic                 timeout,
    output logic                 blink_tick,
    output logic [N_BTN-1:0]     leds,
    output logic [ADDR_W-1:0]    db_limit,
    output logic [ADDR_W-1:0]    db_addr,
    output logic [N_BTN-1:0]     db_expected,
    output logic [N_BTN-1:0]     db_play
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX = '1;

    logic [ADDR_W-1:0] limit, addr, rd_idx;
    logic [N_BTN-1:0]  play, expected;
    logic [BANK_W-1:0] bank_eff;
    logic              rom_vld, q0, q1, blink_phase;
    logic [ERR_W-1:0]  err_cnt, rd_data;
    logic [ERR_W-1:0]  err_mem [DEPTH];
    logic [1:0]        tmr_en, tmr_clr, tmr_tick;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          limit <= '0;
        else if (clr_limit) limit <= '0;
        else if (inc_limit) limit <= (limit == LAST) ? '0 : limit + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         addr <= '0;
        else if (clr_addr) addr <= '0;
        else if (inc_addr) addr <= (addr == LAST) ? '0 : addr + 1'b1;
    end

    assign bank_eff = (int'(bank_sel) < N_BANKS) ? bank_sel : '0;

    // rom_vld keeps play_match low until the first ROM word has been read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expected <= '0;
            rom_vld  <= 1'b0;
            play     <= '0;
            q0       <= 1'b0;
            q1       <= 1'b0;
        end else begin
            expected <= N_BTN'(rom_word(int'(bank_eff), int'(addr), N_BTN));
            rom_vld  <= 1'b1;
            q0       <= |btn;
            q1       <= q0;
            if (load_play) play <= btn;
        end
    end

    assign play_match  = rom_vld && (expected == play);
    assign play_pulse  = q0 & ~q1;
    assign multi_press = |(btn & (btn - N_BTN'(1)));

    assign tmr_en  = {cnt_blink, cnt_timeout};
    assign tmr_clr = {clr_blink, clr_timeout};

    for (genvar g = 0; g < 2; g++) begin : g_tmr
        localparam int M  = (g == 0) ? TIMEOUT_CYC : BLINK_CYC;
        localparam int TW = (M > 1) ? $clog2(M) : 1;
        logic [TW-1:0] cnt;
        assign tmr_tick[g] = tmr_en[g] && (cnt == TW'(M - 1));
        always_ff @(posedge clock or posedge reset) begin
            if (reset)           cnt <= '0;
            else if (tmr_clr[g]) cnt <= '0;
            else if (tmr_en[g])  cnt <= tmr_tick[g] ? '0 : cnt + 1'b1;
        end
    end

    assign timeout    = tmr_tick[0];
    assign blink_tick = tmr_tick[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)           blink_phase <= 1'b0;
        else if (blink_tick) blink_phase <= ~blink_phase;
    end

    always_comb begin
        leds = '0;
        unique case (led_mode)
            LED_OFF:   leds = '0;
            LED_EXP:   leds = expected;
            LED_BTN:   leds = btn;
            LED_BLINK: leds = blink_phase ? expected : '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        err_cnt <= '0;
        else if (err_clr) err_cnt <= '0;
        else if (err_inc && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
    end

    // The scorer owns the RAM while busy; round writes are dropped then.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) err_mem[i] <= '0;
        end else if (err_clr_mem) begin
            for (int i = 0; i < DEPTH; i++) err_mem[i] <= '0;
        end else if (err_write && !sif.score_busy) begin
            err_mem[limit] <= err_cnt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= err_mem[rd_idx];
    end

    seq_game_score_unit #(
        .DEPTH      (DEPTH),
        .ERR_W      (ERR_W),
        .SCORE_W    (SCORE_W),
        .SCORE_INIT (SCORE_INIT)
    ) u_score (
        .clock   (clock),
        .reset   (reset),
        .sif     (sif),
        .limit   (limit),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign limit_at_level = (limit == level_len);
    assign addr_eq_limit  = (addr == limit);
    assign addr_last      = (addr == LAST);
    assign db_limit       = limit;
    assign db_addr        = addr;
    assign db_expected    = expected;
    assign db_play        = play;

endmodule

// File: tb/tb_seq_game_datapath_p.sv
// Scoreboard bench for seq_game_datapath_p: stimulus queues expectations,
// a negedge monitor pops and compares them, a second queue tracks score_done.
module tb_seq_game_datapath_p;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] btn = '0;
    logic [0:0] bank_sel = '0;
    logic [3:0] level_len = '0;
    logic clr_limit = 0, inc_limit = 0, clr_addr = 0, inc_addr = 0;
    logic load_play = 0, clr_timeout = 0, cnt_timeout = 0;
    logic clr_blink = 0, cnt_blink = 0;
    logic [1:0] led_mode = '0;
    logic err_clr = 0, err_inc = 0, err_write = 0, err_clr_mem = 0;
    logic limit_at_level, addr_eq_limit, addr_last, play_match;
    logic play_pulse, multi_press, timeout, blink_tick;
    logic [6:0] leds, db_expected, db_play;
    logic [3:0] db_limit, db_addr;

    seq_game_datapath_p_if #(.SCORE_W(8)) sif ();

    always #5 clock = ~clock;

    seq_game_datapath_p dut (
        .clock(clock), .reset(reset), .btn(btn), .bank_sel(bank_sel),
        .level_len(level_len), .clr_limit(clr_limit), .inc_limit(inc_limit),
        .clr_addr(clr_addr), .inc_addr(inc_addr), .load_play(load_play),
        .clr_timeout(clr_timeout), .cnt_timeout(cnt_timeout),
        .clr_blink(clr_blink), .cnt_blink(cnt_blink), .led_mode(led_mode),
        .err_clr(err_clr), .err_inc(err_inc), .err_write(err_write),
        .err_clr_mem(err_clr_mem), .sif(sif),
        .limit_at_level(limit_at_level), .addr_eq_limit(addr_eq_limit),
        .addr_last(addr_last), .play_match(play_match),
        .play_pulse(play_pulse), .multi_press(multi_press),
        .timeout(timeout), .blink_tick(blink_tick), .leds(leds),
        .db_limit(db_limit), .db_addr(db_addr),
        .db_expected(db_expected), .db_play(db_play)
    );

    localparam int S_SCORE = 0, S_LEDS = 1, S_PP = 2, S_TO = 3, S_BT = 4;
    localparam int S_LIM = 5, S_ADDR = 6, S_MATCH = 7, S_MULTI = 8;
    localparam int S_EXP = 9, S_PLAY = 10, S_BUSY = 11, S_DONE = 12;
    localparam int S_LAL = 13, S_AEL = 14, S_ALAST = 15;
    localparam int S_TOCNT = 16, S_BTCNT = 17;

    typedef struct {
        int    due;
        int    id;
        int    exp;
        string name;
    } chk_t;

    typedef struct {
        int due;
        int score;
    } done_t;

    chk_t  q[$];
    done_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    to_cnt = 0;
    int    bt_cnt = 0;
    int    s0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int obs(int id);
        case (id)
            S_SCORE: return int'(sif.score);
            S_LEDS:  return int'(leds);
            S_PP:    return int'(play_pulse);
            S_TO:    return int'(timeout);
            S_BT:    return int'(blink_tick);
            S_LIM:   return int'(db_limit);
            S_ADDR:  return int'(db_addr);
            S_MATCH: return int'(play_match);
            S_MULTI: return int'(multi_press);
            S_EXP:   return int'(db_expected);
            S_PLAY:  return int'(db_play);
            S_BUSY:  return int'(sif.score_busy);
            S_DONE:  return int'(sif.score_done);
            S_LAL:   return int'(limit_at_level);
            S_AEL:   return int'(addr_eq_limit);
            S_ALAST: return int'(addr_last);
            S_TOCNT: return to_cnt;
            S_BTCNT: return bt_cnt;
            default: return -1;
        endcase
    endfunction

    always @(negedge clock) begin
        if (timeout) to_cnt++;
        if (blink_tick) bt_cnt++;
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t c;
            c = q.pop_front();
            checks++;
            if (obs(c.id) != c.exp) begin
                errors++;
                $display("FAIL %s: got %0d want %0d (cycle %0d)",
                         c.name, obs(c.id), c.exp, cyc);
            end
        end
        if (sif.score_done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done at cycle %0d want none",
                         cyc);
            end else begin
                done_t d;
                d = dq.pop_front();
                if (d.due != cyc || d.score != int'(sif.score)) begin
                    errors++;
                    $display("FAIL done: got cycle %0d score %0d want cycle %0d score %0d",
                             cyc, sif.score, d.due, d.score);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(string name, int id, int exp, int ofs = 0);
        q.push_back('{due: cyc + ofs, id: id, exp: exp, name: name});
    endtask

    task automatic run_score(int lat, int exp_score);
        sif.score_start = 1'b1;
        dq.push_back('{due: cyc + lat, score: exp_score});
        chk("busy_run", S_BUSY, 1, 1);
        chk("busy_done", S_BUSY, 0, lat);
        tick();
        sif.score_start = 1'b0;
        tick(lat + 1);
    endtask

    initial begin
        sif.score_clr   = 1'b0;
        sif.score_start = 1'b0;
        tick(2);
        chk("rst_score", S_SCORE, 100);
        chk("rst_leds", S_LEDS, 0);
        chk("rst_pulse", S_PP, 0);
        chk("rst_timeout", S_TO, 0);
        chk("rst_blink", S_BT, 0);
        chk("rst_limit", S_LIM, 0);
        chk("rst_addr", S_ADDR, 0);
        chk("rst_match", S_MATCH, 0);
        chk("rst_busy", S_BUSY, 0);
        chk("rst_done", S_DONE, 0);
        tick();
        reset = 1'b0;
        level_len = 4'd2;

        // ROM walk with loaded plays
        tick();
        btn = 7'b0000001; load_play = 1;
        chk("multi_one", S_MULTI, 0);
        tick();
        load_play = 0; btn = '0;
        chk("match_a0", S_MATCH, 1);
        chk("exp_a0", S_EXP, 1);
        chk("play_a0", S_PLAY, 1);
        inc_addr = 1;
        tick();
        inc_addr = 0; btn = 7'b0000010; load_play = 1;
        chk("addr_1", S_ADDR, 1);
        tick();
        load_play = 0; btn = '0;
        chk("match_a1", S_MATCH, 1);
        chk("exp_a1", S_EXP, 2);
        inc_addr = 1;
        tick();
        inc_addr = 0; btn = 7'b0000011; load_play = 1;
        tick();
        load_play = 0;
        chk("addr_2", S_ADDR, 2);
        chk("exp_a2", S_EXP, 4);
        chk("play_a2", S_PLAY, 3);
        chk("match_multi", S_MATCH, 0);
        chk("multi_two", S_MULTI, 1);
        chk("lim_at_lvl0", S_LAL, 0);
        chk("addr_eq_lim0", S_AEL, 0);
        led_mode = 2'b10;
        chk("leds_btn", S_LEDS, 3);
        tick();
        led_mode = 2'b01;
        chk("leds_exp", S_LEDS, 4);
        tick();
        led_mode = 2'b11;
        chk("leds_blink_off", S_LEDS, 0);
        tick();
        led_mode = 2'b00; btn = '0;

        // limit/addr counters
        inc_limit = 1;
        tick(2);
        inc_limit = 0;
        chk("limit_2", S_LIM, 2);
        chk("lim_at_lvl1", S_LAL, 1);
        chk("addr_eq_lim1", S_AEL, 1);
        clr_limit = 1; inc_limit = 1;
        tick();
        clr_limit = 0; inc_limit = 0;
        chk("limit_clr_prio", S_LIM, 0);
        inc_addr = 1;
        tick(13);
        inc_addr = 0;
        chk("addr_15", S_ADDR, 15);
        chk("addr_last1", S_ALAST, 1);
        inc_addr = 1;
        tick();
        inc_addr = 0;
        chk("addr_wrap", S_ADDR, 0);
        chk("addr_last0", S_ALAST, 0);
        tick(2);

        // one press held five cycles
        btn = 7'b0001000;
        chk("pulse_k0", S_PP, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) btn = '0;
            chk($sformatf("pulse_k%0d", k), S_PP, (k == 1) ? 1 : 0);
        end

        // timeout and blink timers
        cnt_timeout = 1;
        chk("to_start", S_TO, 0);
        chk("to_early", S_TO, 0, 4998);
        chk("to_pulse", S_TO, 1, 4999);
        tick(5000);
        cnt_timeout = 0;
        chk("to_after", S_TO, 0);
        chk("to_count", S_TOCNT, 1);
        cnt_blink = 1; led_mode = 2'b11;
        chk("blink_pulse", S_BT, 1, 499);
        chk("leds_phase0", S_LEDS, 0, 499);
        tick(500);
        cnt_blink = 0;
        chk("blink_count", S_BTCNT, 1);
        chk("leds_phase1", S_LEDS, 1);
        tick();
        led_mode = 2'b00;
        bank_sel = 1'b1;
        chk("bank_lat", S_EXP, 1);
        tick();
        chk("bank1_a0", S_EXP, 8);
        bank_sel = 1'b0;
        tick();

        // 6 errors in round 0: 100 - 15*3
        err_clr = 1;
        tick();
        err_clr = 0; err_inc = 1;
        tick(6);
        err_inc = 0; err_write = 1;
        tick();
        err_write = 0;
        run_score(3, 55);

        // start and write while busy are ignored
        sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        chk("score_clr", S_SCORE, 100);
        err_clr = 1;
        tick();
        err_clr = 0;
        sif.score_start = 1;
        dq.push_back('{due: cyc + 3, score: 55});
        tick();
        sif.score_start = 0; err_write = 1;
        tick();
        err_write = 0; sif.score_start = 1;
        tick();
        sif.score_start = 0;
        tick(3);
        sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        run_score(3, 55);

        // saturated error count, then four heavy rounds
        err_clr = 1;
        tick();
        err_clr = 0; err_inc = 1;
        tick(20);
        err_inc = 0; err_write = 1;
        tick();
        err_write = 0; sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        run_score(3, 0);
        for (int r = 1; r <= 3; r++) begin
            inc_limit = 1;
            tick();
            inc_limit = 0; err_write = 1;
            tick();
            err_write = 0;
        end
        chk("limit_3", S_LIM, 3);
        sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        run_score(9, 0);

        // score_clr mid-run
        sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        sif.score_start = 1;
        tick();
        sif.score_start = 0;
        tick(2);
        chk("mid_score", S_SCORE, 0);
        chk("mid_busy", S_BUSY, 1);
        sif.score_clr = 1;
        tick();
        sif.score_clr = 0;
        chk("clr_mid_score", S_SCORE, 100);
        chk("clr_mid_busy", S_BUSY, 0);
        tick(10);
        chk("clr_late_score", S_SCORE, 100);

        // reset mid-run
        s0 = cyc;
        sif.score_start = 1;
        tick();
        sif.score_start = 0;
        tick(2);
        reset = 1'b1;
        chk("rst_mid_score", S_SCORE, 100);
        chk("rst_mid_busy", S_BUSY, 0);
        chk("rst_mid_limit", S_LIM, 0);
        tick(3);
        reset = 1'b0;
        tick(12);

        while (q.size() > 0) begin
            chk_t c;
            c = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got unchecked want due cycle %0d", c.name, c.due);
        end
        while (dq.size() > 0) begin
            done_t d;
            d = dq.pop_front();
            checks++;
            errors++;
            $display("FAIL done_missing: got none want cycle %0d score %0d",
                     d.due, d.score);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
